// File: rtl/sys_array_result_collector.sv
// sys_array_result_collector
//
// Takes the diagonally skewed column outputs from the bottom edge of the
// systolic array and lines them back up into whole rows. It checks that every
// aligned row is consistent and queues good rows in a FIFO. It then streams
// the rows out over a valid/ready interface and counts them against the row
// total of the current job, so it can flag the final row and signal completion.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   mac_in      per-column signed partial sums, column 0 in the LSBs
//   active_in   per-column result-valid flags, bit 0 is column 0
//   start       job start pulse, only honoured while idle
//   row_count   number of rows in the job, captured on start
//   busy        job in progress (collecting or draining)
//   out_data    aligned result row at the FIFO head, column 0 in the LSBs
//   out_valid   out_data holds a row
//   out_ready   downstream accepts out_data
//   out_last    out_data is the final row of the job
//   done        single-cycle pulse when the job has fully drained
//   overflow    sticky: a row was lost because the FIFO was full
//   skew_err    sticky: an aligned row had only some columns active
//   fifo_level  current FIFO occupancy

module sys_array_result_collector #(
    parameter int rows_num   = 4,
    parameter int fifo_depth = 8,
    parameter int cnt_width  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [16*rows_num-1:0]        mac_in,
    input  logic [rows_num-1:0]           active_in,
    input  logic                          start,
    input  logic [cnt_width-1:0]          row_count,
    output logic                          busy,
    output logic [16*rows_num-1:0]        out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          done,
    output logic                          overflow,
    output logic                          skew_err,
    output logic [$clog2(fifo_depth):0]   fifo_level
);

    localparam int row_w = 16 * rows_num;
    localparam int ptr_w = $clog2(fifo_depth);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    state_t state;
    state_t next_state;

    logic [row_w-1:0]    skew_data;
    logic [rows_num-1:0] skew_act;
    logic [row_w-1:0]    align_data;
    logic [rows_num-1:0] align_act;

    logic                row_full;
    logic                row_skewed;
    logic                collect_row;
    logic                last_row;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;

    logic [cnt_width-1:0] target;
    logic [cnt_width-1:0] accepted;
    logic [cnt_width-1:0] next_accepted;

    logic [row_w:0]       mem [fifo_depth];
    logic [row_w:0]       head;
    logic [ptr_w-1:0]     wr_ptr;
    logic [ptr_w-1:0]     rd_ptr;
    logic [ptr_w:0]       level;

    // Column j arrives j cycles after column 0, so it gets rows_num-1-j
    // delay stages. The last column has no stage and feeds the common
    // alignment register directly.
    for (genvar j = 0; j < rows_num; j++) begin : g_col
        localparam int depth = rows_num - 1 - j;
        if (depth == 0) begin : g_direct
            assign skew_data[16*j +: 16] = mac_in[16*j +: 16];
            assign skew_act[j]           = active_in[j];
        end else begin : g_delay
            logic [15:0]      data_pipe [depth];
            logic [depth-1:0] act_pipe;

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < depth; k++) begin
                        data_pipe[k] <= '0;
                    end
                    act_pipe <= '0;
                end else begin
                    data_pipe[0] <= mac_in[16*j +: 16];
                    act_pipe[0]  <= active_in[j];
                    for (int k = 1; k < depth; k++) begin
                        data_pipe[k] <= data_pipe[k-1];
                        act_pipe[k]  <= act_pipe[k-1];
                    end
                end
            end

            assign skew_data[16*j +: 16] = data_pipe[depth-1];
            assign skew_act[j]           = act_pipe[depth-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            align_data <= '0;
            align_act  <= '0;
        end else begin
            align_data <= skew_data;
            align_act  <= skew_act;
        end
    end

    // A partially active aligned row means the columns drifted apart. Such a
    // row is flagged and dropped instead of being stored.
    assign row_full   = &align_act;
    assign row_skewed = (|align_act) && !row_full;

    assign fifo_full  = (level == (ptr_w+1)'(fifo_depth));
    assign fifo_empty = (level == '0);
    assign pop        = out_valid && out_ready;

    assign collect_row   = (state == COLLECT) && row_full;
    assign next_accepted = accepted + cnt_width'(1);
    assign last_row      = collect_row && (next_accepted == target);

    // A full FIFO can still take a row when the head leaves in the same cycle.
    assign push = collect_row && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (row_count == '0) ? DRAIN : COLLECT;
                end
            end
            COLLECT: begin
                if (last_row) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Done and the falling edge of busy coincide: both come from the last
    // DRAIN cycle with an empty FIFO.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            COLLECT: busy = 1'b1;
            DRAIN: begin
                busy = !fifo_empty;
                done = fifo_empty;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // A row lost to a full FIFO still counts, so the job always terminates.
    always_ff @(posedge clk) begin
        if (reset) begin
            target   <= '0;
            accepted <= '0;
            overflow <= 1'b0;
            skew_err <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                target   <= row_count;
                accepted <= '0;
                overflow <= 1'b0;
                skew_err <= 1'b0;
            end
            if (collect_row) begin
                accepted <= next_accepted;
                if (fifo_full && !pop) begin
                    overflow <= 1'b1;
                end
            end
            if ((state == COLLECT) && row_skewed) begin
                skew_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (ptr_w+1)'(1);
                2'b01:   level <= level - (ptr_w+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; the outputs are gated by out_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {last_row, align_data};
        end
    end

    assign head       = mem[rd_ptr];
    assign out_valid  = !fifo_empty;
    assign out_data   = out_valid ? head[row_w-1:0] : '0;
    assign out_last   = out_valid && head[row_w];
    assign fifo_level = level;

endmodule

// File: doc/sys_array_result_collector.md
Name: sys_array_result_collector

Overview:
- Sits at the bottom edge of the systolic array and consumes its column outputs: per-column partial sums and per-column active flags.
- Results leave the array diagonally skewed: column j lags column 0 by j cycles. This block removes the skew, checks alignment and buffers whole result rows in a FIFO.
- It drains the FIFO over a valid/ready stream toward the output buffer and counts rows per job so it can signal last and done.

Parameters:
- rows_num, 4, array dimension; equals the number of columns delivered per row.
- fifo_depth, 8, FIFO entries in aligned rows; power of two, at least 2.
- cnt_width, 16, width of the row counter and of row_count.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mac_in  in  16*rows_num  signed partial sums from the array bottom; column 0 in the LSBs.
- active_in  in  rows_num  per-column result-valid from the array bottom; bit 0 is column 0.
- start  in  1  one-cycle pulse that begins a job; sampled only in IDLE.
- row_count  in  cnt_width  rows expected for the job; latched on start.
- busy  out  1  high in COLLECT and DRAIN.
- out_data  out  16*rows_num  aligned result row; column 0 in the LSBs.
- out_valid  out  1  out_data holds a valid row.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  high with the final row of the job.
- done  out  1  one-cycle pulse when the job is complete.
- overflow  out  1  sticky: a row arrived while the FIFO was full.
- skew_err  out  1  sticky: an aligned row had only some active bits set.
- fifo_level  out  clog2(fifo_depth)+1  current FIFO occupancy.

Behaviour:
- Reset: every output is 0, the FIFO is empty, counters are 0 and the FSM is in IDLE.
- Deskew: column j's data and active bit pass through (rows_num-1-j) delay registers, then one common alignment register shared by all columns.
- A row whose column 0 is sampled at edge n is aligned at edge n+rows_num-1. It is written to the FIFO at edge n+rows_num.
- When the FIFO is empty, out_valid rises in the cycle after edge n+rows_num; total latency is rows_num+1 edges.
- Alignment check on the aligned active vector:
  - all ones: the row is valid.
  - all zeros: no row is present.
  - any other value: set skew_err and drop the row; it is neither written nor counted.
- FSM states are IDLE, COLLECT and DRAIN.
- IDLE:
  - On start, latch row_count, clear the accepted-row counter, overflow and skew_err, and go to COLLECT.
  - If the latched row_count is 0, go to DRAIN instead of COLLECT.
  - Aligned rows arriving in IDLE are discarded.
- COLLECT:
  - Each valid aligned row is written to the FIFO and the accepted counter increments.
  - If the FIFO is full and no pop happens in that cycle, the row is dropped, overflow is set and the counter still increments so the job terminates.
  - When the counter reaches the latched count, go to DRAIN.
  - Valid rows beyond the count are discarded.
- DRAIN:
  - When the FIFO is empty and no output handshake is pending, pulse done for 1 cycle and return to IDLE.
  - busy falls in the same cycle done is high.
- FIFO:
  - Show-ahead: out_data is the head entry, registered.
  - A pop occurs when out_valid and out_ready are both high.
  - A simultaneous push and pop while full is legal: no overflow, and the level is unchanged.
  - out_data and out_valid stay stable while out_valid is high and out_ready is low.
  - The pointers wrap modulo fifo_depth.
- out_last is stored per FIFO entry: it is set on the entry written when the counter reaches the latched count.
- start while busy is ignored.
- Reset mid-job returns the block to IDLE, empties the FIFO and drops in-flight deskew contents.
- Data passes through unchanged (16-bit signed, no arithmetic); the deskew registers also carry the sign bit unchanged.

Test Plan:
- rows_num=4, row_count=1: inject column j = 100+j with active bit j at cycle 10+j, out_ready=1. Required: out_data = {103,102,101,100} with out_valid in the cycle after edge 14; out_last=1; done pulses afterward.
- row_count=3, three back-to-back skewed rows, out_ready=1. Required: three consecutive outputs, out_last only on the third, skew_err=0, overflow=0.
- fifo_depth=8, row_count=10, out_ready=0. Required: fifo_level saturates at 8 and overflow=1. After raising out_ready, exactly 8 rows come out in order, and done pulses after the 8th.
- Column 2's active bit delayed by one extra cycle. Required: skew_err=1, that row is dropped and the counter is unchanged.
- Negative values (-1, -32768) in all columns. Required: out_data preserves the bit patterns exactly.
- Assert reset during COLLECT with 3 rows buffered. Required: out_valid=0, fifo_level=0 and busy=0 on the next cycle; a new start then works normally.
